// File: rtl/seq_calc_unit.sv
// seq_calc_unit: W-bit two's-complement accumulator calculator.
// Add/subtract finish in one cycle, multiply is radix-2 Booth and divide is restoring.
module seq_calc_unit #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         equals_i,
  input  logic         add_i,
  input  logic         subtract_i,
  input  logic         multiply_i,
  input  logic         divide_i,
  input  logic [W-1:0] number_i,
  output logic [W-1:0] result_o,
  output logic         overflow_o,
  output logic         busy_o
);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_NONE} op_t;
  typedef enum logic [1:0] {X_IDLE, X_MUL, X_DIV, X_DIV_FIX} st_t;

  st_t st_q, st_d;
  op_t p_q, p_d, np_q, np_d, key_op;
  logic [W-1:0] a_q, a_d, m_q, m_d, quo_q, quo_d, rem_q, rem_d;
  logic [W-2:0] dvs_q, dvs_d;
  logic [2*W:0] prod_q, prod_d, prod_n;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, neg_q, neg_d;
  logic key_any, accept, last, ge, add_ovf, sub_ovf, mul_ovf, div_err;
  logic [W-1:0] n_tc, a_mag, sum, diff;
  logic [W:0] booth_sum, r_sh;

  always_comb begin
    key_any   = equals_i | add_i | subtract_i | multiply_i | divide_i;
    key_op    = equals_i ? OP_NONE : add_i ? OP_ADD : subtract_i ? OP_SUB :
                multiply_i ? OP_MUL : OP_DIV;
    accept    = (st_q == X_IDLE) && !ovf_q && !clear_i && key_any;
    last      = cnt_q == LAST;
    n_tc      = number_i[W-1] ? -{1'b0, number_i[W-2:0]} : {1'b0, number_i[W-2:0]};
    a_mag     = a_q[W-1] ? -a_q : a_q;
    sum       = a_q + n_tc;
    diff      = a_q - n_tc;
    add_ovf   = (a_q[W-1] == n_tc[W-1]) && (sum[W-1] != a_q[W-1]);
    sub_ovf   = (a_q[W-1] != n_tc[W-1]) && (diff[W-1] != a_q[W-1]);
    div_err   = (number_i[W-2:0] == '0) || ((a_q == {1'b1, {(W-1){1'b0}}}) && (n_tc == '1));
    // Upper half is widened by one bit so negating the most negative multiplicand stays exact
    booth_sum = {prod_q[2*W], prod_q[2*W:W+1]} +
                ((prod_q[1:0] == 2'b01) ? {m_q[W-1], m_q} :
                 (prod_q[1:0] == 2'b10) ? -{m_q[W-1], m_q} : '0);
    prod_n    = {booth_sum, prod_q[W:1]};
    mul_ovf   = prod_n[2*W:W] != {(W+1){prod_n[W]}};
    r_sh      = {rem_q, quo_q[W-1]};
    ge        = r_sh >= {2'b00, dvs_q};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st_q <= X_IDLE;
    else st_q <= st_d;

  always_comb begin
    st_d = st_q;
    if (clear_i) st_d = X_IDLE;
    else
      case (st_q)
        X_IDLE:  st_d = !accept ? X_IDLE : (p_q == OP_MUL) ? X_MUL :
                        ((p_q == OP_DIV) && !div_err) ? X_DIV : X_IDLE;
        X_MUL:   st_d = last ? X_IDLE : X_MUL;
        X_DIV:   st_d = last ? X_DIV_FIX : X_DIV;
        default: st_d = X_IDLE;
      endcase
  end

  always_comb begin
    result_o   = a_q;
    overflow_o = ovf_q;
    busy_o     = st_q != X_IDLE;
  end

  always_comb begin
    a_d    = a_q;
    p_d    = p_q;
    np_d   = np_q;
    ovf_d  = ovf_q;
    m_d    = m_q;
    prod_d = prod_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    neg_d  = neg_q;
    cnt_d  = ((st_q == X_MUL) || (st_q == X_DIV)) && !last ? cnt_q + CW'(1) : '0;
    if (clear_i) begin
      a_d   = '0;
      p_d   = OP_ADD;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (accept) begin
      p_d  = key_op;
      np_d = key_op;
      case (p_q)
        OP_ADD: begin
          a_d   = add_ovf ? a_q : sum;
          ovf_d = add_ovf;
        end
        OP_SUB: begin
          a_d   = sub_ovf ? a_q : diff;
          ovf_d = sub_ovf;
        end
        OP_MUL: begin
          p_d    = p_q;
          m_d    = a_q;
          prod_d = {{W{1'b0}}, n_tc, 1'b0};
        end
        OP_DIV: begin
          p_d   = div_err ? key_op : p_q;
          ovf_d = div_err;
          quo_d = a_mag;
          rem_d = '0;
          dvs_d = number_i[W-2:0];
          neg_d = a_q[W-1] ^ number_i[W-1];
        end
        default: ;
      endcase
    end else if (st_q == X_MUL) begin
      prod_d = prod_n;
      if (last) begin
        p_d   = np_q;
        a_d   = mul_ovf ? a_q : prod_n[W:1];
        ovf_d = mul_ovf;
      end
    end else if (st_q == X_DIV) begin
      rem_d = W'(ge ? r_sh - {2'b00, dvs_q} : r_sh);
      quo_d = {quo_q[W-2:0], ge};
    end else if (st_q == X_DIV_FIX) begin
      a_d = neg_q ? -quo_q : quo_q;
      p_d = np_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q    <= '0;
      p_q    <= OP_ADD;
      np_q   <= OP_NONE;
      ovf_q  <= 1'b0;
      m_q    <= '0;
      prod_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      p_q    <= p_d;
      np_q   <= np_d;
      ovf_q  <= ovf_d;
      m_q    <= m_d;
      prod_q <= prod_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
    end
endmodule

// File: tb/tb_seq_calc_unit.sv
// tb_seq_calc_unit: directed key sequences with a queue-based scoreboard and a separate monitor.
module tb_seq_calc_unit;
  localparam int W = 11;
  localparam logic [5:0] K_CLR = 6'b100000, K_EQ = 6'b010000, K_ADD = 6'b001000,
                         K_SUB = 6'b000100, K_MUL = 6'b000010, K_DIV = 6'b000001;

  typedef struct {
    string name;
    int    res;
    int    ovf;
    int    busy;
    int    len;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic clear_i = 1'b0, equals_i = 1'b0, add_i = 1'b0;
  logic subtract_i = 1'b0, multiply_i = 1'b0, divide_i = 1'b0;
  logic [W-1:0] number_i = '0;
  logic [W-1:0] result_o;
  logic overflow_o, busy_o;
  exp_t sb[$];
  int checks = 0, failures = 0, busy_run = 0;
  logic busy_prev = 1'b0;

  seq_calc_unit #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .equals_i(equals_i), .add_i(add_i),
    .subtract_i(subtract_i), .multiply_i(multiply_i), .divide_i(divide_i),
    .number_i(number_i), .result_o(result_o), .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, act, act, exp, exp);
    end
  endtask

  task automatic push(input string name, input int res, input int ovf, input int busy, input int len);
    exp_t e;
    e.name = name;
    e.res  = res;
    e.ovf  = ovf;
    e.busy = busy;
    e.len  = len;
    sb.push_back(e);
  endtask

  task automatic press(input logic [5:0] k, input int num, input string name,
                       input int res, input int ovf, input int busy);
    @(negedge clk);
    {clear_i, equals_i, add_i, subtract_i, multiply_i, divide_i} = k;
    number_i = W'(num);
    push(name, res, ovf, busy, -1);
    @(negedge clk);
    {clear_i, equals_i, add_i, subtract_i, multiply_i, divide_i} = '0;
  endtask

  task automatic wait_idle(input string name, input int res, input int ovf, input int len);
    int n = 0;
    while (busy_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) chk({name, " busy timeout"}, 1, 0);
    push(name, res, ovf, 0, len);
    @(negedge clk);
  endtask

  // Length of the most recent busy run, sampled just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    busy_run  = (busy_o && !busy_prev) ? 1 : busy_o ? busy_run + 1 : busy_run;
    busy_prev = busy_o;
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, " result"}, int'(result_o), e.res);
        chk({e.name, " overflow"}, int'(overflow_o), e.ovf);
        chk({e.name, " busy"}, int'(busy_o), e.busy);
        if (e.len >= 0) chk({e.name, " busy cycles"}, busy_run, e.len);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    push("reset", 0, 0, 0, -1);
    @(negedge clk);
    rst_n = 1'b1;
    press(K_ADD, 5, "add 5", 5, 0, 0);
    press(K_SUB, 3, "sub 3", 8, 0, 0);
    press(K_EQ, 2, "eq 2", 6, 0, 0);
    press(K_CLR, 0, "clr", 0, 0, 0);
    press(K_ADD, 'h419, "add -25", 'h7E7, 0, 0);
    press(K_MUL, 0, "mul key", 'h7E7, 0, 0);
    press(K_EQ, 40, "mul start", 'h7E7, 0, 1);
    press(K_ADD, 5, "mid-mul key", 'h7E7, 0, 1);
    wait_idle("-25x40", 'h418, 0, 11);
    press(K_ADD, 7, "chain after eq", 'h418, 0, 0);
    press(K_CLR, 0, "clr", 0, 0, 0);
    press(K_ADD, 100, "add 100", 100, 0, 0);
    press(K_MUL, 0, "mul key", 100, 0, 0);
    press(K_EQ, 11, "mul ovf start", 100, 0, 1);
    wait_idle("100x11 ovf", 100, 1, 11);
    press(K_ADD, 5, "add while ovf", 100, 1, 0);
    press(K_CLR, 0, "clr ovf", 0, 0, 0);
    press(K_ADD, 'h464, "add -100", 'h79C, 0, 0);
    press(K_DIV, 0, "div key", 'h79C, 0, 0);
    press(K_EQ, 7, "div start", 'h79C, 0, 1);
    wait_idle("-100/7", 'h7F2, 0, 12);
    press(K_CLR, 0, "clr", 0, 0, 0);
    press(K_ADD, 'h464, "add -100", 'h79C, 0, 0);
    press(K_DIV, 0, "div key", 'h79C, 0, 0);
    press(K_EQ, 0, "div by 0", 'h79C, 1, 0);
    press(K_CLR, 0, "clr", 0, 0, 0);
    press(K_ADD, 'h7FF, "add -1023", 'h401, 0, 0);
    press(K_SUB, 0, "sub key", 'h401, 0, 0);
    press(K_DIV, 1, "sub 1", 'h400, 0, 0);
    press(K_EQ, 'h401, "-1024/-1", 'h400, 1, 0);
    press(K_CLR, 0, "clr", 0, 0, 0);
    press(K_ADD, 1000, "add 1000", 'h3E8, 0, 0);
    press(K_DIV, 0, "div key", 'h3E8, 0, 0);
    press(K_EQ, 'h403, "div start", 'h3E8, 0, 1);
    wait_idle("1000/-3", 'h6B3, 0, 12);
    press(K_CLR, 0, "clr", 0, 0, 0);
    press(K_ADD, 1000, "add 1000", 'h3E8, 0, 0);
    press(K_EQ, 0, "eq", 'h3E8, 0, 0);
    press(K_ADD, 9, "add after eq", 'h3E8, 0, 0);
    press(K_ADD, 'h400, "add -0", 'h3E8, 0, 0);
    press(K_ADD, 100, "add ovf", 'h3E8, 1, 0);
    press(K_CLR, 0, "clr", 0, 0, 0);
    press(K_ADD, 'h7FF, "add -1023", 'h401, 0, 0);
    press(K_SUB, 0, "sub key", 'h401, 0, 0);
    press(K_EQ, 5, "sub ovf", 'h401, 1, 0);
    press(K_CLR, 0, "clr", 0, 0, 0);
    press(K_ADD, 7, "add 7", 7, 0, 0);
    press(K_EQ | K_ADD, 3, "eq over add", 10, 0, 0);
    press(K_ADD, 50, "after eq prio", 10, 0, 0);
    press(K_CLR | K_ADD, 5, "clr over add", 0, 0, 0);
    press(K_ADD, 6, "add 6", 6, 0, 0);
    press(K_MUL | K_DIV, 0, "mul over div", 6, 0, 0);
    press(K_EQ, 2, "mul start", 6, 0, 1);
    wait_idle("6x2", 12, 0, 11);
    press(K_CLR, 0, "clr", 0, 0, 0);
    press(K_ADD, 3, "add 3", 3, 0, 0);
    press(K_MUL, 0, "mul key", 3, 0, 0);
    press(K_EQ, 5, "mul start", 3, 0, 1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset result", int'(result_o), 0);
    chk("async reset busy", int'(busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    press(K_ADD, 4, "add after reset", 4, 0, 0);
    press(K_DIV, 0, "div key", 4, 0, 0);
    press(K_EQ, 2, "div start", 4, 0, 1);
    @(negedge clk);
    press(K_CLR, 0, "clr mid div", 0, 0, 0);
    press(K_ADD, 9, "add after clr", 9, 0, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
